// File: rtl/spi_tx_drain.sv
// SPI mode-0 slave transmitter draining a FWFT byte FIFO onto MISO, MSB first; optional SPI_TX_UNDERRUN_CNT_EN adds a saturating underrun counter.
// Latency: SCK/CS_N edges act SYNC_STAGES+1 cycles after the pin; a loaded byte reaches MISO one cycle after its load point.
// Backpressure: none; an empty FIFO at a load point sends FILL and pulses o_underrun, and the FIFO is never popped while empty.
module spi_tx_drain #(
    parameter logic [7:0] FILL        = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_sck,
    input  logic       i_cs_n,
    output logic       o_miso,
    output logic       o_miso_oe,
    input  logic [7:0] i_fifo_data,
    input  logic       i_fifo_empty,
    output logic       o_fifo_rd,
    output logic       o_byte_done,
    output logic       o_underrun,
    output logic       o_busy
`ifdef SPI_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0] o_underrun_cnt,
    input  logic       i_underrun_clr
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_hist;
    logic                   cs_hist;
    logic [7:0]             shreg, shreg_nxt;
    logic [2:0]             bit_cnt, bit_cnt_nxt;
    logic                   miso_q, miso_nxt;
    logic                   oe_q, oe_nxt;
    logic                   load;

    // Synchronisers preset to the bus-idle levels so reset release never looks like an edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sck_sync <= '0;
            cs_sync  <= '1;
            sck_hist <= 1'b0;
            cs_hist  <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], i_sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            sck_hist <= sck_sync[SYNC_STAGES-1];
            cs_hist  <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s, cs_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist;
    assign sck_fall = ~sck_s & sck_hist;
    assign cs_rise  = cs_s & ~cs_hist;
    assign cs_fall  = ~cs_s & cs_hist;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            shreg   <= FILL;
            bit_cnt <= 3'd0;
            miso_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            miso_q  <= miso_nxt;
            oe_q    <= oe_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        miso_nxt    = miso_q;
        oe_nxt      = oe_q;
        o_fifo_rd   = 1'b0;
        o_underrun  = 1'b0;
        o_byte_done = 1'b0;
        load        = 1'b0;

        // Deselect wins over any SCK edge seen in the same cycle.
        if (cs_rise) begin
            state_nxt   = IDLE;
            oe_nxt      = 1'b0;
            miso_nxt    = 1'b1;
            bit_cnt_nxt = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    if (sck_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        o_byte_done = (bit_cnt == 3'd7);
                    end else if (sck_fall) begin
                        if (bit_cnt == 3'd0) begin
                            load = 1'b1;
                        end else begin
                            shreg_nxt = {shreg[6:0], 1'b0};
                            miso_nxt  = shreg[6];
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (load) begin
            bit_cnt_nxt = 3'd0;
            oe_nxt      = 1'b1;
            if (!i_fifo_empty) begin
                shreg_nxt = i_fifo_data;
                miso_nxt  = i_fifo_data[7];
                o_fifo_rd = 1'b1;
            end else begin
                shreg_nxt  = FILL;
                miso_nxt   = FILL[7];
                o_underrun = 1'b1;
            end
        end
    end

    assign o_miso    = miso_q;
    assign o_miso_oe = oe_q;
    assign o_busy    = (state != IDLE);

`ifdef SPI_TX_UNDERRUN_CNT_EN
    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_underrun_cnt <= 8'd0;
        end else if (i_underrun_clr) begin
            o_underrun_cnt <= 8'd0;
        end else if (o_underrun && (o_underrun_cnt != 8'hFF)) begin
            o_underrun_cnt <= o_underrun_cnt + 8'd1;
        end
    end
`else
    // Underrun statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_spi_tx_drain.sv
// Bench for spi_tx_drain: queue-based FIFO and SPI master, with a byte-stream model of what MISO must carry.
module tb_spi_tx_drain;

    localparam int         SYNC = 2;
    localparam logic [7:0] FILL = 8'hFF;

    logic       i_clk        = 1'b0;
    logic       i_reset_n    = 1'b0;
    logic       i_sck        = 1'b0;
    logic       i_cs_n       = 1'b1;
    logic [7:0] i_fifo_data  = 8'h00;
    logic       i_fifo_empty = 1'b1;
    logic       o_miso, o_miso_oe, o_fifo_rd, o_byte_done, o_underrun, o_busy;
`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic [7:0] o_underrun_cnt;
    logic       i_underrun_clr = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    spi_tx_drain #(.FILL(FILL), .SYNC_STAGES(SYNC)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_sck        (i_sck),
        .i_cs_n       (i_cs_n),
        .o_miso       (o_miso),
        .o_miso_oe    (o_miso_oe),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd    (o_fifo_rd),
        .o_byte_done  (o_byte_done),
        .o_underrun   (o_underrun),
        .o_busy       (o_busy)
`ifdef SPI_TX_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt (o_underrun_cnt),
        .i_underrun_clr (i_underrun_clr)
`endif
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] fq[$];
    int         cnt_rd = 0, cnt_done = 0, cnt_und = 0;
    bit         pop_pending = 0;
    bit         mon_en = 0;
    int         cs_age = 0;
    logic       cs_prev = 1'b1;
    logic [31:0] rx;
    int         d_rd, d_done, d_und;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model, pulse counters and per-cycle protocol checks.
    always @(negedge i_clk) begin
        if (pop_pending) begin
            if (fq.size() > 0) void'(fq.pop_front());
            pop_pending = 0;
        end
        if (i_reset_n) begin
            if (o_fifo_rd) begin
                cnt_rd++;
                pop_pending = 1;
            end
            if (o_byte_done) cnt_done++;
            if (o_underrun) cnt_und++;
        end
        cs_age  = (i_cs_n != cs_prev) ? 0 : cs_age + 1;
        cs_prev = i_cs_n;
        if (mon_en) begin
            check("rd_while_empty", {31'd0, o_fifo_rd & i_fifo_empty}, 32'd0);
            if (i_cs_n && cs_age > SYNC + 2)
                check("idle_outputs",
                      {26'd0, o_miso, o_miso_oe, o_busy, o_fifo_rd, o_underrun, o_byte_done},
                      32'b100000);
            if (!i_cs_n && cs_age > SYNC + 2)
                check("selected_oe_busy", {30'd0, o_miso_oe, o_busy}, 32'b11);
        end
        i_fifo_empty = (fq.size() == 0);
        i_fifo_data  = (fq.size() == 0) ? 8'($urandom) : fq[0];
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // One CS_N-framed transfer of nrise SCK cycles; CS_N rises with the last SCK fall unless late.
    task automatic do_xfer(input string tag, input int nrise, input bit late, input int half);
        logic [7:0] snap[$];
        logic [7:0] byt;
        int qs, feff, loads, pops, r0, d0, u0;
        snap = fq;
        qs   = snap.size();
        r0 = cnt_rd; d0 = cnt_done; u0 = cnt_und;
        rx = '0;
        i_cs_n = 1'b0;
        cyc(SYNC + 6);
        for (int j = 0; j < nrise; j++) begin
            byt = (j / 8 < qs) ? snap[j / 8] : FILL;
            check($sformatf("%s_bit%0d", tag, j), {31'd0, o_miso}, {31'd0, byt[7 - j % 8]});
            rx = {rx[30:0], o_miso};
            i_sck = 1'b1;
            cyc(half);
            i_sck = 1'b0;
            if (j == nrise - 1 && !late) i_cs_n = 1'b1;
            cyc(half);
        end
        if (late) i_cs_n = 1'b1;
        cyc(SYNC + 6);
        feff  = late ? nrise : nrise - 1;
        loads = 1 + feff / 8;
        pops  = (loads < qs) ? loads : qs;
        d_rd   = cnt_rd - r0;
        d_done = cnt_done - d0;
        d_und  = cnt_und - u0;
        check({tag, "_pops"}, d_rd, pops);
        check({tag, "_underruns"}, d_und, loads - pops);
        check({tag, "_byte_done"}, d_done, nrise / 8);
        check({tag, "_fifo_left"}, fq.size(), qs - pops);
        check({tag, "_oe_after"}, {31'd0, o_miso_oe}, 32'd0);
    endtask

    initial begin
        cyc(3);
        check("reset_outputs",
              {26'd0, o_miso, o_miso_oe, o_fifo_rd, o_byte_done, o_underrun, o_busy}, 32'b100000);
        i_reset_n = 1'b1;
        cyc(3);
        mon_en = 1;

        fq.push_back(8'hA5); fq.push_back(8'h3C);
        cyc(2);
        do_xfer("t1", 16, 0, 6);
        check("t1_rx", rx[15:0], 16'hA53C);
        check("t1_rd_lit", d_rd, 2);
        check("t1_done_lit", d_done, 2);
        check("t1_und_lit", d_und, 0);

        do_xfer("t2", 8, 0, 6);
        check("t2_rx", rx[7:0], 8'hFF);
        check("t2_und_lit", d_und, 1);
        check("t2_rd_lit", d_rd, 0);

        fq.push_back(8'h81);
        cyc(2);
        do_xfer("t3", 16, 0, 7);
        check("t3_rx", rx[15:0], 16'h81FF);
        check("t3_rd_lit", d_rd, 1);
        check("t3_und_lit", d_und, 1);

        fq.push_back(8'hC3); fq.push_back(8'h5A);
        cyc(2);
        do_xfer("t4a", 4, 1, 6);
        check("t4a_rx", rx[3:0], 4'hC);
        check("t4a_rd_lit", d_rd, 1);
        do_xfer("t4b", 8, 0, 6);
        check("t4b_rx", rx[7:0], 8'h5A);
        check("t4b_rd_lit", d_rd, 1);

        // Reset during bit 5 of a byte.
        fq.push_back(8'h99); fq.push_back(8'h42);
        cyc(2);
        i_cs_n = 1'b0;
        cyc(SYNC + 6);
        for (int j = 0; j < 5; j++) begin
            i_sck = 1'b1; cyc(6); i_sck = 1'b0; cyc(6);
        end
        i_sck = 1'b1; cyc(3);
        mon_en = 0;
        i_reset_n = 1'b0;
        #1;
        check("t5_async_reset",
              {26'd0, o_miso, o_miso_oe, o_fifo_rd, o_byte_done, o_underrun, o_busy}, 32'b100000);
        i_sck = 1'b0; i_cs_n = 1'b1;
        cyc(4);
        i_reset_n = 1'b1;
        cyc(4);
        check("t5_fifo_left", fq.size(), 1);
        mon_en = 1;
        do_xfer("t5", 8, 0, 6);
        check("t5_rx", rx[7:0], 8'h42);

        for (int t = 0; t < 40; t++) begin
            int npush;
            npush = $urandom_range(0, 3);
            for (int k = 0; k < npush; k++) fq.push_back(8'($urandom));
            cyc(2);
            do_xfer($sformatf("r%0d", t), $urandom_range(1, 24), 1'($urandom_range(0, 1)),
                    $urandom_range(6, 9));
        end

`ifdef SPI_TX_UNDERRUN_CNT_EN
        fq.delete();
        i_underrun_clr = 1'b1; cyc(1); i_underrun_clr = 1'b0; cyc(1);
        check("cnt_cleared", o_underrun_cnt, 8'h00);
        do_xfer("t6", 2400, 0, 6);
        check("t6_und_total", d_und, 300);
        check("cnt_saturated", o_underrun_cnt, 8'hFF);
        i_underrun_clr = 1'b1; cyc(1); i_underrun_clr = 1'b0; cyc(1);
        check("cnt_clear_after_sat", o_underrun_cnt, 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
